// File: rtl/vga_pkg.sv
// Shared VGA timing constants, widths and capture FSM types.
// The generator and the capture receiver both import this package.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;

  localparam int CH_W    = 4;
  localparam int RGB_W   = 3 * CH_W;
  localparam int COORD_W = 11;
  localparam int SUM_W   = 16;
  localparam int MATCH_W = 4;

  localparam logic [COORD_W-1:0] COORD_MAX = '1;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  typedef struct packed {
    state_t             state;
    logic [MATCH_W-1:0] match_cnt;
    logic               hs_assert;
    logic               hs_deassert;
    logic               vs_deassert;
  } dbg_t;

  // Counters stick at their maximum instead of wrapping.
  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (v == COORD_MAX) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/vga_capture_rx_if.sv
// Video bus from the pattern generator to the capture receiver.
// There is no handshake: every signal is sampled on each pixel clock, and r/g/b carry meaning only while de is high.
interface vga_capture_rx_if;
  import vga_pkg::*;
  logic [CH_W-1:0] r;
  logic [CH_W-1:0] g;
  logic [CH_W-1:0] b;
  logic            hsync;
  logic            vsync;
  logic            de;

  modport master (output r, g, b, hsync, vsync, de);
  modport slave  (input  r, g, b, hsync, vsync, de);
endinterface

// File: rtl/vga_sync_edge.sv
// Polarity-normalising edge detector that produces single-cycle pulses on the assert and deassert edges.
// The history register resets to "deasserted", so a level that is already active when reset releases reports an assert edge.
module vga_sync_edge #(
  parameter bit ACT_LOW = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_assert,
  output logic o_deassert
);
  logic w_lvl;
  logic r_prev;

  assign w_lvl = i_sig ^ ACT_LOW;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_prev <= 1'b0;
    else          r_prev <= w_lvl;
  end

  assign o_assert   =  w_lvl & ~r_prev;
  assign o_deassert = ~w_lvl &  r_prev;
endmodule

// File: rtl/vga_capture_rx.sv
// Loopback capture for the VGA output: recovers pixel coordinates, measures the active area,
// accumulates a per-frame checksum and tracks timing lock.
module vga_capture_rx #(
  parameter int H_ACTIVE     = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE     = vga_pkg::V_ACTIVE,
  parameter bit SYNC_ACT_LOW = 1'b1,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  vga_capture_rx_if.slave              vid,
  output logic [vga_pkg::COORD_W-1:0]  o_pix_x,
  output logic [vga_pkg::COORD_W-1:0]  o_pix_y,
  output logic [vga_pkg::RGB_W-1:0]    o_pix_rgb,
  output logic                         o_pix_valid,
  output logic                         o_frame_done,
  output logic [vga_pkg::SUM_W-1:0]    o_frame_sum,
  output logic [vga_pkg::COORD_W-1:0]  o_meas_w,
  output logic [vga_pkg::COORD_W-1:0]  o_meas_h,
  output logic                         o_locked,
  output logic                         o_timing_err,
  output vga_pkg::dbg_t                o_dbg
);
  import vga_pkg::*;

  localparam logic SYNC_IDLE = SYNC_ACT_LOW;

  logic [RGB_W-1:0]   r_rgb;
  logic               r_de, r_hs, r_vs;
  logic [COORD_W-1:0] r_x, r_y, r_last_w;
  logic [SUM_W-1:0]   r_sum;
  logic               r_frame_bad;
  logic [MATCH_W-1:0] r_match, w_match_d;
  state_t             r_state, w_state_d;

  logic               w_vs_edge, w_vs_fall, w_hs_rise, w_hs_fall, w_de_rise, w_de_fall;
  logic [COORD_W-1:0] w_x_nxt, w_y_upd, w_w_upd;
  logic [COORD_W:0]   w_len;
  logic [SUM_W-1:0]   w_sum_upd;
  logic               w_x_sat, w_bad_upd, w_good, w_fd, w_te;

  // Stage 1 registers the inputs. The syncs reset to their idle level so that reset itself does not create a spurious frame edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rgb <= '0;
      r_de  <= 1'b0;
      r_hs  <= SYNC_IDLE;
      r_vs  <= SYNC_IDLE;
    end else begin
      r_rgb <= {vid.r, vid.g, vid.b};
      r_de  <= vid.de;
      r_hs  <= vid.hsync;
      r_vs  <= vid.vsync;
    end
  end

  vga_sync_edge #(.ACT_LOW(SYNC_ACT_LOW)) u_vs_edge (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sig(r_vs), .o_assert(w_vs_edge), .o_deassert(w_vs_fall));
  vga_sync_edge #(.ACT_LOW(SYNC_ACT_LOW)) u_hs_edge (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sig(r_hs), .o_assert(w_hs_rise), .o_deassert(w_hs_fall));
  vga_sync_edge #(.ACT_LOW(1'b0)) u_de_edge (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sig(r_de), .o_assert(w_de_rise), .o_deassert(w_de_fall));

  // While de is low, x holds the last pixel index, so the line length at the falling edge is x+1.
  assign w_x_nxt   = !r_de ? r_x : (w_de_rise ? '0 : sat_inc(r_x));
  assign w_x_sat   = r_de & ~w_de_rise & (r_x == COORD_MAX);
  assign w_len     = {1'b0, r_x} + 1'b1;
  assign w_y_upd   = w_de_fall ? sat_inc(r_y) : r_y;
  assign w_w_upd   = !w_de_fall ? r_last_w : (w_len[COORD_W] ? COORD_MAX : w_len[COORD_W-1:0]);
  assign w_sum_upd = r_sum + (r_de ? SUM_W'(r_rgb) : '0);
  assign w_bad_upd = r_frame_bad | w_x_sat | (w_vs_edge & r_de)
                   | (w_de_fall & (w_len != (COORD_W+1)'(H_ACTIVE)));
  assign w_good    = ~w_bad_upd & (w_y_upd == COORD_W'(V_ACTIVE));

  always_comb begin
    w_state_d = r_state;
    w_match_d = r_match;
    w_fd      = 1'b0;
    w_te      = 1'b0;
    if (w_vs_edge) begin
      case (r_state)
        SEARCH: begin
          w_state_d = MEASURE;
          w_match_d = '0;
        end
        MEASURE: begin
          w_fd = 1'b1;
          if (w_good) begin
            w_match_d = r_match + 1'b1;
            if (w_match_d == MATCH_W'(LOCK_FRAMES)) w_state_d = LOCKED;
          end else begin
            w_match_d = '0;
          end
        end
        LOCKED: begin
          w_fd = 1'b1;
          if (!w_good) begin
            w_state_d = SEARCH;
            w_match_d = '0;
            w_te      = 1'b1;
          end
        end
        default: w_state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= SEARCH;
      r_match <= '0;
    end else begin
      r_state <= w_state_d;
      r_match <= w_match_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_x          <= '0;
      r_y          <= '0;
      r_last_w     <= '0;
      r_sum        <= '0;
      r_frame_bad  <= 1'b0;
      o_pix_x      <= '0;
      o_pix_y      <= '0;
      o_pix_rgb    <= '0;
      o_pix_valid  <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_sum  <= '0;
      o_meas_w     <= '0;
      o_meas_h     <= '0;
      o_locked     <= 1'b0;
      o_timing_err <= 1'b0;
    end else begin
      r_x          <= w_x_nxt;
      r_last_w     <= w_w_upd;
      r_y          <= w_vs_edge ? '0   : w_y_upd;
      r_sum        <= w_vs_edge ? '0   : w_sum_upd;
      r_frame_bad  <= w_vs_edge ? 1'b0 : w_bad_upd;
      o_pix_x      <= w_x_nxt;
      o_pix_y      <= r_y;
      o_pix_rgb    <= r_rgb;
      o_pix_valid  <= r_de;
      o_frame_done <= w_fd;
      o_timing_err <= w_te;
      o_locked     <= (w_state_d == LOCKED);
      if (w_fd) begin
        o_meas_w    <= w_w_upd;
        o_meas_h    <= w_y_upd;
        o_frame_sum <= w_sum_upd;
      end
    end
  end

  always_comb begin
    o_dbg             = '0;
    o_dbg.state       = r_state;
    o_dbg.match_cnt   = r_match;
    o_dbg.hs_assert   = w_hs_rise;
    o_dbg.hs_deassert = w_hs_fall;
    o_dbg.vs_deassert = w_vs_fall;
  end
endmodule

// File: tb/tb_vga_capture_rx.sv
// Directed bench for vga_capture_rx that uses a reduced 16x8 active raster to keep frames short.
// The expected widths, heights, checksums and lock transitions are computed by hand for each frame.
module tb_vga_capture_rx;
  import vga_pkg::*;

  localparam int HA = 16;
  localparam int VA = 8;
  localparam int LT = HA + 4;
  localparam int NEVER = 1 << 30;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  vga_capture_rx_if vif();

  logic [COORD_W-1:0] o_pix_x, o_pix_y, o_meas_w, o_meas_h;
  logic [RGB_W-1:0]   o_pix_rgb;
  logic [SUM_W-1:0]   o_frame_sum;
  logic               o_pix_valid, o_frame_done, o_locked, o_timing_err;
  dbg_t               o_dbg;

  vga_capture_rx #(.H_ACTIVE(HA), .V_ACTIVE(VA), .SYNC_ACT_LOW(1'b1), .LOCK_FRAMES(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .vid(vif),
    .o_pix_x(o_pix_x), .o_pix_y(o_pix_y), .o_pix_rgb(o_pix_rgb), .o_pix_valid(o_pix_valid),
    .o_frame_done(o_frame_done), .o_frame_sum(o_frame_sum), .o_meas_w(o_meas_w),
    .o_meas_h(o_meas_h), .o_locked(o_locked), .o_timing_err(o_timing_err), .o_dbg(o_dbg));

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int te_cnt = 0;
  int lat_cyc = 0;
  int lat_obs_cyc = 0;
  logic lat_seen = 1'b0;
  logic [COORD_W-1:0] lat_x = '0, lat_y = '0;
  logic lat_valid = 1'b0;
  logic cap_locked = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge away from the active edge
  always @(negedge i_clk) begin
    if (o_frame_done) begin
      fd_cnt     <= fd_cnt + 1;
      cap_locked <= o_locked;
    end
    if (o_timing_err) te_cnt <= te_cnt + 1;
    if (!lat_seen && o_pix_rgb == 12'hABC) begin
      lat_seen    <= 1'b1;
      lat_obs_cyc <= cyc;
      lat_x       <= o_pix_x;
      lat_y       <= o_pix_y;
      lat_valid   <= o_pix_valid;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_cyc(input logic de, input logic hs_a, input logic vs_a,
                           input logic [11:0] rgb, input bit mark);
    vif.de    = de;
    vif.hsync = ~hs_a;
    vif.vsync = ~vs_a;
    {vif.r, vif.g, vif.b} = de ? rgb : 12'h000;
    if (mark) lat_cyc = cyc;
    tick();
  endtask

  // vs_mode 0: vsync asserts at the start of vblank; 1: vsync asserts on the same cycle de falls on the last line;
  // 2: vsync asserts 4 cycles before the last line's de falls.
  task automatic drive_frame(input int n_lines, input int bad_line, input int bad_len,
                             input int vs_mode, input logic [11:0] rgb, input bit lat);
    for (int l = 0; l < n_lines; l++) begin
      int w;
      int vs_from;
      w = (l == bad_line) ? bad_len : HA;
      vs_from = NEVER;
      if (l == n_lines - 1 && vs_mode == 1) vs_from = w;
      if (l == n_lines - 1 && vs_mode == 2) vs_from = w - 4;
      for (int c = 0; c < w + 4; c++) begin
        bit m;
        m = lat && (l == 7) && (c == 5);
        drive_cyc(c < w, (c == w + 1) || (c == w + 2), c >= vs_from, m ? 12'hABC : rgb, m);
      end
    end
    for (int l = 0; l < 3; l++)
      for (int c = 0; c < LT; c++)
        drive_cyc(1'b0, (c == 1) || (c == 2), l < 2, 12'h000, 1'b0);
  endtask

  task automatic good_frame();
    drive_frame(VA, -1, 0, 0, 12'h001, 1'b0);
  endtask

  initial begin
    vif.de = 1'b0; vif.hsync = 1'b1; vif.vsync = 1'b1;
    vif.r = '0; vif.g = '0; vif.b = '0;
    repeat (4) tick();
    i_rst_n = 1'b1;

    // Start a frame, then apply reset in the middle of a line
    for (int l = 0; l < 3; l++)
      for (int c = 0; c < LT; c++) drive_cyc(c < HA, 1'b0, 1'b0, 12'h123, 1'b0);
    i_rst_n = 1'b0;
    for (int c = 0; c < 4; c++) drive_cyc(1'b1, 1'b0, 1'b0, 12'hFFF, 1'b0);
    check("rst_pix_valid", o_pix_valid, 0);
    check("rst_pix_xyrgb", {o_pix_x, o_pix_y, o_pix_rgb}, 0);
    check("rst_sum_w_h", {o_frame_sum, o_meas_w}, 0);
    check("rst_meas_h", o_meas_h, 0);
    check("rst_flags", {o_frame_done, o_locked, o_timing_err}, 0);
    check("rst_state", 32'(o_dbg.state), 32'(SEARCH));
    i_rst_n = 1'b1;
    for (int c = 0; c < LT; c++) drive_cyc(1'b0, 1'b0, 1'b0, 12'h000, 1'b0);

    // The first close only leaves SEARCH
    good_frame();
    check("search_no_fd", fd_cnt, 0);
    check("state_measure", 32'(o_dbg.state), 32'(MEASURE));
    good_frame();
    check("fd_first", fd_cnt, 1);
    check("meas_w", o_meas_w, HA);
    check("meas_h", o_meas_h, VA);
    check("sum_001", o_frame_sum, 16'h0080);
    check("unlocked_1good", o_locked, 0);
    good_frame();
    check("locked_at_fd", cap_locked, 1);
    check("locked_2good", o_locked, 1);

    // Latency check: a single marked pixel at column 5, row 7
    drive_frame(VA, -1, 0, 0, 12'h001, 1'b1);
    check("lat_seen", lat_seen, 1);
    check("lat_cycles", lat_obs_cyc - lat_cyc, 2);
    check("lat_valid", lat_valid, 1);
    check("lat_x", lat_x, 5);
    check("lat_y", lat_y, 7);
    check("sum_mark", o_frame_sum, 16'h0B3B);
    drive_frame(VA, -1, 0, 0, 12'hFFF, 1'b0);
    check("sum_wrap", o_frame_sum, 16'hFF80);

    // A short line while LOCKED
    drive_frame(VA, 3, HA - 1, 0, 12'h001, 1'b0);
    check("badw_te", te_cnt, 1);
    check("badw_unlock", o_locked, 0);
    check("badw_meas_h", o_meas_h, VA);
    check("badw_fd", fd_cnt, 5);
    good_frame();
    check("resync_no_fd", fd_cnt, 5);
    good_frame();
    check("relock_1", o_locked, 0);
    good_frame();
    check("relock_2", o_locked, 1);

    // vsync assert coincides with de falling on the last line: that line still counts
    drive_frame(VA, -1, 0, 1, 12'h001, 1'b0);
    check("coinc_meas_h", o_meas_h, VA);
    check("coinc_locked", o_locked, 1);
    check("coinc_no_te", te_cnt, 1);

    // vsync asserts while de is high: the line is truncated
    drive_frame(VA, -1, 0, 2, 12'h001, 1'b0);
    check("trunc_te", te_cnt, 2);
    check("trunc_unlock", o_locked, 0);
    check("trunc_meas_h", o_meas_h, VA - 1);

    // A short frame in MEASURE clears the match count
    good_frame();
    good_frame();
    drive_frame(VA - 1, -1, 0, 0, 12'h001, 1'b0);
    check("badh_meas_h", o_meas_h, VA - 1);
    check("badh_locked", o_locked, 0);
    good_frame();
    check("badh_relock_1", o_locked, 0);
    good_frame();
    check("badh_relock_2", o_locked, 1);

    // An overlong last line saturates x
    drive_frame(VA, VA - 1, 2050, 0, 12'h001, 1'b0);
    check("sat_meas_w", o_meas_w, 2047);
    check("sat_te", te_cnt, 3);
    check("sat_unlock", o_locked, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
